// File: rtl/endpoint_pkg.sv
// endpoint_pkg: shared widths, flit header layout, RX buffer entry and FSM
// state types for the node endpoint.
package endpoint_pkg;

  localparam int FLIT_W = 16;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;

  // Header flit: payload length in the upper byte, destination in the lower.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] dest;
  } flit_hdr_t;

  // One RX buffer entry: packet framing tags plus the flit itself.
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [FLIT_W-1:0] flit;
  } rx_entry_t;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} tx_state_t;

  typedef enum logic [1:0] {RX_HEAD, RX_BODY, RX_DROP} rx_state_t;

endpackage

// File: rtl/node_endpoint_if.sv
// node_endpoint_if: request/payload/delivery streams and the router local
// port of a node endpoint. The endpoint uses the slave modport; the
// environment (driver or router model) uses the master modport.
interface node_endpoint_if;
  import endpoint_pkg::*;

  logic              tx_req_valid;
  logic              tx_req_ready;
  logic [ADDR_W-1:0] tx_req_dest;
  logic [LEN_W-1:0]  tx_req_len;
  logic              tx_data_valid;
  logic              tx_data_ready;
  logic [FLIT_W-1:0] tx_data;
  logic              sending_data;
  logic [FLIT_W-1:0] data_out;
  logic              buffer_full_in;
  logic              receiving_data;
  logic [FLIT_W-1:0] data_in;
  logic              buffer_full_out;
  logic              rx_valid;
  logic              rx_ready;
  logic [FLIT_W-1:0] rx_data;
  logic              rx_sop;
  logic              rx_eop;
  logic              rx_overflow;
  logic [7:0]        rx_drop_cnt;

  modport slave (
    input  tx_req_valid, tx_req_dest, tx_req_len, tx_data_valid, tx_data,
           buffer_full_in, receiving_data, data_in, rx_ready,
    output tx_req_ready, tx_data_ready, sending_data, data_out,
           buffer_full_out, rx_valid, rx_data, rx_sop, rx_eop,
           rx_overflow, rx_drop_cnt
  );

  modport master (
    output tx_req_valid, tx_req_dest, tx_req_len, tx_data_valid, tx_data,
           buffer_full_in, receiving_data, data_in, rx_ready,
    input  tx_req_ready, tx_data_ready, sending_data, data_out,
           buffer_full_out, rx_valid, rx_data, rx_sop, rx_eop,
           rx_overflow, rx_drop_cnt
  );

endinterface

// File: rtl/endpoint_rx_fifo.sv
// endpoint_rx_fifo: RX buffer of DEPTH 18-bit entries (sop, eop, flit).
// A push while full is refused unless a pop happens in the same cycle.
// almost_full is registered and reflects occupancy >= DEPTH-1 after update.
module endpoint_rx_fifo
  import endpoint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rx_entry_t push_entry,
  input  logic      pop,
  output rx_entry_t head_entry,
  output logic      empty,
  output logic      overflow,
  output logic      almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            push_ok;
  logic            pop_ok;

  assign empty      = (count == '0);
  assign pop_ok     = pop && !empty;
  assign push_ok    = push && ((count != CNT_FULL) || pop_ok);
  assign overflow   = push && !push_ok;
  assign head_entry = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered near-full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      almost_full <= (count_nxt >= CNT_FULL - 1'b1);
    end
  end

  // Entry storage; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/node_endpoint.sv
// node_endpoint: packetizes requests into header + payload flits toward the
// router local port and parses incoming flits into a framed RX stream.
// Optional build macro ENDPOINT_ADDR_CHECK_EN: drop received packets whose
// destination differs from {NODE_X[3:0], NODE_Y[3:0]} and count them.
module node_endpoint
  import endpoint_pkg::*;
#(
  parameter int NODE_X   = 0,
  parameter int NODE_Y   = 0,
  parameter int RX_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  node_endpoint_if.slave ep
);

  localparam logic [ADDR_W-1:0] LOCAL_ADDR = {4'(NODE_X), 4'(NODE_Y)};

  tx_state_t        tx_state, tx_state_nxt;
  logic [LEN_W-1:0] tx_rem, tx_rem_nxt;
  flit_hdr_t        tx_hdr;
  logic             tx_latch;

  rx_state_t        rx_state, rx_state_nxt;
  logic [LEN_W-1:0] rx_rem, rx_rem_nxt;
  flit_hdr_t        rx_hdr;
  logic             addr_miss;
  logic             push;
  logic             drop_hit;
  logic             fifo_empty;
  logic             fifo_overflow;
  rx_entry_t        push_entry;
  rx_entry_t        head_entry;
  logic [7:0]       drop_cnt;
  logic             overflow_q;

  // TX state and remaining payload count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_rem   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_rem   <= tx_rem_nxt;
    end
  end

  // Capture the accepted request; only read while in HEAD
  always_ff @(posedge clk) begin
    if (tx_latch) tx_hdr <= '{len: ep.tx_req_len, dest: ep.tx_req_dest};
  end

  // TX sequencing: header first, then len payload flits, gated by buffer_full_in
  always_comb begin
    tx_state_nxt     = tx_state;
    tx_rem_nxt       = tx_rem;
    tx_latch         = 1'b0;
    ep.tx_req_ready  = 1'b0;
    ep.tx_data_ready = 1'b0;
    ep.sending_data  = 1'b0;
    ep.data_out      = '0;
    case (tx_state)
      IDLE: begin
        ep.tx_req_ready = 1'b1;
        if (ep.tx_req_valid) begin
          tx_latch     = 1'b1;
          tx_state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (!ep.buffer_full_in) begin
          ep.sending_data = 1'b1;
          ep.data_out     = tx_hdr;
          tx_rem_nxt      = tx_hdr.len;
          tx_state_nxt    = (tx_hdr.len == '0) ? IDLE : BODY;
        end
      end
      BODY: begin
        ep.tx_data_ready = !ep.buffer_full_in;
        if (ep.tx_data_valid && !ep.buffer_full_in) begin
          ep.sending_data = 1'b1;
          ep.data_out     = ep.tx_data;
          tx_rem_nxt      = tx_rem - 1'b1;
          if (tx_rem == 8'd1) tx_state_nxt = IDLE;
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  assign rx_hdr = ep.data_in;

`ifdef ENDPOINT_ADDR_CHECK_EN
  assign addr_miss = (rx_hdr.dest != LOCAL_ADDR);
`else
  // Address is ignored when checking is compiled out
  logic unused_addr;
  assign unused_addr = ^{LOCAL_ADDR, rx_hdr.dest};
  assign addr_miss   = 1'b0;
`endif

  // RX parse: tag header/last flit, or swallow a misaddressed packet
  always_comb begin
    rx_state_nxt = rx_state;
    rx_rem_nxt   = rx_rem;
    push         = 1'b0;
    drop_hit     = 1'b0;
    push_entry   = '{sop: 1'b0, eop: 1'b0, flit: ep.data_in};
    if (ep.receiving_data) begin
      case (rx_state)
        RX_HEAD: begin
          rx_rem_nxt = rx_hdr.len;
          if (addr_miss) begin
            drop_hit = 1'b1;
            if (rx_hdr.len != '0) rx_state_nxt = RX_DROP;
          end else begin
            push           = 1'b1;
            push_entry.sop = 1'b1;
            push_entry.eop = (rx_hdr.len == '0);
            if (rx_hdr.len != '0) rx_state_nxt = RX_BODY;
          end
        end
        RX_BODY: begin
          push           = 1'b1;
          push_entry.eop = (rx_rem == 8'd1);
          rx_rem_nxt     = rx_rem - 1'b1;
          if (rx_rem == 8'd1) rx_state_nxt = RX_HEAD;
        end
        RX_DROP: begin
          rx_rem_nxt = rx_rem - 1'b1;
          if (rx_rem == 8'd1) rx_state_nxt = RX_HEAD;
        end
        default: rx_state_nxt = RX_HEAD;
      endcase
    end
  end

  // RX parse state, sticky overflow and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_HEAD;
      rx_rem     <= '0;
      drop_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_rem   <= rx_rem_nxt;
      if (drop_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      if (fifo_overflow) overflow_q <= 1'b1;
    end
  end

  endpoint_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (ep.rx_ready),
    .head_entry  (head_entry),
    .empty       (fifo_empty),
    .overflow    (fifo_overflow),
    .almost_full (ep.buffer_full_out)
  );

  assign ep.rx_valid    = !fifo_empty;
  assign ep.rx_data     = fifo_empty ? '0 : head_entry.flit;
  assign ep.rx_sop      = !fifo_empty && head_entry.sop;
  assign ep.rx_eop      = !fifo_empty && head_entry.eop;
  assign ep.rx_overflow = overflow_q;
  assign ep.rx_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_node_endpoint.sv
// tb_node_endpoint: directed and randomized checks of node_endpoint against a
// packet-level reference model (expected TX flit list, RX delivery queue).
// Honors ENDPOINT_ADDR_CHECK_EN when the build defines it.
module tb_node_endpoint;
  import endpoint_pkg::*;

`ifdef ENDPOINT_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam logic [7:0]  LOCAL    = 8'h11;
  localparam int          RX_DEPTH = 4;
  localparam logic [15:0] HDR035   = ADDR_CHECK ? 16'h0111 : 16'h0100;

  typedef struct packed { logic dlv; logic sop; logic eop; } tag_t;
  typedef struct packed { logic sop; logic eop; logic [15:0] d; } ent_t;

  logic clk;
  logic rst;
  node_endpoint_if bus();

  node_endpoint #(.NODE_X(1), .NODE_Y(1), .RX_DEPTH(RX_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .ep  (bus)
  );

  int total = 0;
  int bad   = 0;
  bit tx_mon = 0;
  tag_t rx_tag;
  int rdy_pct = 0;
  logic [15:0] tx_exp_q [$];
  ent_t mq [$];
  bit m_ovf;
  bit m_bfo;
  int m_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // TX scoreboard: every sent flit must be the next expected one
  always @(negedge clk) begin
    if (rst) tx_exp_q.delete();
    else if (tx_mon) begin
      check_eq("tx_gate", 32'((bus.sending_data | bus.tx_data_ready) & bus.buffer_full_in), 0);
      if (bus.sending_data) begin
        if (tx_exp_q.size() == 0) check_eq("tx_extra", {16'h0, bus.data_out}, 32'hFFFF_FFFF);
        else check_eq("tx_flit", bus.data_out, tx_exp_q.pop_front());
      end else begin
        check_eq("tx_zero", bus.data_out, 0);
      end
    end
  end

  // RX reference: bounded queue of delivered entries, sticky overflow, drop count
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf  = 0;
      m_bfo  = 0;
      m_drop = 0;
    end else begin
      check_eq("rx_valid", bus.rx_valid, mq.size() != 0);
      if (mq.size() != 0) check_eq("rx_ent", {bus.rx_sop, bus.rx_eop, bus.rx_data}, mq[0]);
      check_eq("rx_bfo", bus.buffer_full_out, m_bfo);
      check_eq("rx_ovf", bus.rx_overflow, m_ovf);
      check_eq("rx_drop", bus.rx_drop_cnt, m_drop);
      if (mq.size() != 0 && bus.rx_ready) void'(mq.pop_front());
      if (bus.receiving_data) begin
        if (rx_tag.dlv) begin
          if (mq.size() < RX_DEPTH) mq.push_back('{sop: rx_tag.sop, eop: rx_tag.eop, d: bus.data_in});
          else m_ovf = 1;
        end else if (rx_tag.sop && m_drop < 255) begin
          m_drop++;
        end
      end
      m_bfo = (mq.size() >= RX_DEPTH - 1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic tx_send(input logic [7:0] dest, input logic [7:0] len,
                         input int gap_pct, input int full_pct, input int stall_from);
    logic [15:0] pl [$];
    bit acc = 0;
    int t = 0;
    int k = 0;
    for (int i = 0; i < len; i++) pl.push_back(16'($urandom));
    tx_exp_q.push_back({len, dest});
    foreach (pl[i]) tx_exp_q.push_back(pl[i]);
    bus.tx_req_valid = 1; bus.tx_req_dest = dest; bus.tx_req_len = len;
    while (!acc && t < 100) begin
      bus.buffer_full_in = ($urandom_range(99) < full_pct);
      @(negedge clk); acc = bus.tx_req_ready;
      tick(); t++;
    end
    bus.tx_req_valid = 0;
    if (!acc) check_eq("tx_req_timeout", 0, 1);
    t = 0;
    while (k < int'(len) && t < 200) begin
      bus.buffer_full_in = (t >= stall_from && t < stall_from + 3) ? 1'b1 :
                           ($urandom_range(99) < full_pct);
      bus.tx_data_valid = ($urandom_range(99) >= gap_pct);
      bus.tx_data = pl[k];
      @(negedge clk);
      if (bus.tx_data_valid && bus.tx_data_ready) k++;
      tick(); t++;
    end
    bus.tx_data_valid = 0;
    if (k < int'(len)) check_eq("tx_body_timeout", k, len);
  endtask

  task automatic rx_drive(input logic [15:0] d, input bit dlv, input bit s, input bit e);
    bus.rx_ready = ($urandom_range(99) < rdy_pct);
    bus.receiving_data = 1; bus.data_in = d; rx_tag = '{dlv: dlv, sop: s, eop: e};
    tick();
    bus.receiving_data = 0; bus.data_in = '0; rx_tag = '0;
  endtask

  task automatic rx_pkt(input logic [7:0] dest, input logic [7:0] len, input int gap_pct);
    bit dlv = !ADDR_CHECK || (dest == LOCAL);
    rx_drive({len, dest}, dlv, 1, len == 0);
    for (int i = 0; i < int'(len); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.rx_ready = ($urandom_range(99) < rdy_pct);
        tick();
      end
      rx_drive(16'($urandom), dlv, 0, i == int'(len) - 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; rx_tag = '0;
    bus.tx_req_valid = 0; bus.tx_req_dest = 0; bus.tx_req_len = 0;
    bus.tx_data_valid = 0; bus.tx_data = 0; bus.buffer_full_in = 0;
    bus.receiving_data = 0; bus.data_in = 0; bus.rx_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sending", bus.sending_data, 0);
    check_eq("rst_data_out", bus.data_out, 0);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_sop_eop", {bus.rx_sop, bus.rx_eop}, 0);
    check_eq("rst_ovf", bus.rx_overflow, 0);
    check_eq("rst_bfo", bus.buffer_full_out, 0);
    check_eq("rst_tx_data_ready", bus.tx_data_ready, 0);
    check_eq("rst_drop", bus.rx_drop_cnt, 0);
    tick(); rst = 0;
    @(negedge clk); check_eq("rst_req_ready", bus.tx_req_ready, 1);
    tick();

    // Basic packet: header then two payload flits on consecutive cycles
    bus.tx_req_valid = 1; bus.tx_req_dest = 8'h21; bus.tx_req_len = 8'd2;
    bus.tx_data_valid = 1; bus.tx_data = 16'hAAAA;
    @(negedge clk); check_eq("b_req_ready", bus.tx_req_ready, 1);
    tick(); bus.tx_req_valid = 0;
    @(negedge clk);
    check_eq("b_hdr", {bus.sending_data, bus.data_out}, {1'b1, 16'h0221});
    check_eq("b_hdr_dready", bus.tx_data_ready, 0);
    tick();
    @(negedge clk);
    check_eq("b_p0", {bus.sending_data, bus.data_out}, {1'b1, 16'hAAAA});
    check_eq("b_p0_dready", bus.tx_data_ready, 1);
    tick(); bus.tx_data = 16'hBBBB;
    @(negedge clk); check_eq("b_p1", {bus.sending_data, bus.data_out}, {1'b1, 16'hBBBB});
    tick(); bus.tx_data_valid = 0;
    @(negedge clk);
    check_eq("b_idle", {bus.tx_req_ready, bus.sending_data}, 2'b10);
    tick();

    // Header-only packets back to back
    bus.tx_req_valid = 1; bus.tx_req_dest = 8'h05; bus.tx_req_len = 8'd0;
    @(negedge clk); check_eq("h0_ready", bus.tx_req_ready, 1);
    tick(); bus.tx_req_dest = 8'h06;
    @(negedge clk);
    check_eq("h0_hdr", {bus.sending_data, bus.data_out}, {1'b1, 16'h0005});
    check_eq("h0_busy", {bus.tx_req_ready, bus.tx_data_ready}, 0);
    tick();
    @(negedge clk);
    check_eq("h1_ready", {bus.tx_req_ready, bus.sending_data}, 2'b10);
    tick(); bus.tx_req_valid = 0;
    @(negedge clk);
    check_eq("h1_hdr", {bus.sending_data, bus.data_out}, {1'b1, 16'h0006});
    check_eq("h1_dready", bus.tx_data_ready, 0);
    tick();

    // Three-cycle back-pressure in the middle of a body, then random traffic
    tx_mon = 1;
    tx_send(8'h34, 8'd4, 0, 0, 2);
    for (int p = 0; p < 40; p++)
      tx_send(8'($urandom), 8'($urandom_range(0, 5)), 30, 25, -10);
    bus.buffer_full_in = 0;
    repeat (10) tick();
    check_eq("tx_drain", tx_exp_q.size(), 0);

    // Reset in the middle of a packet abandons the rest of it
    tx_exp_q.push_back(16'h0512); tx_exp_q.push_back(16'h5000); tx_exp_q.push_back(16'h5001);
    bus.tx_req_valid = 1; bus.tx_req_dest = 8'h12; bus.tx_req_len = 8'd5;
    bus.tx_data_valid = 1; bus.tx_data = 16'h5000;
    tick(); bus.tx_req_valid = 0;
    tick();
    tick(); bus.tx_data = 16'h5001;
    tick(); bus.tx_data = 16'h5002;
    check_eq("mid_rst_sent", tx_exp_q.size(), 0);
    rst = 1;
    tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mid_rst_quiet", {bus.sending_data, bus.tx_req_ready}, 2'b01);
      tick();
    end
    bus.tx_data_valid = 0;

    // RX fill with no consumer: near-full at 3, overflow from the 5th flit
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) begin
      rx_drive((i % 2) ? 16'h0F00 + 16'(i) : HDR035, 1, (i % 2) == 0, (i % 2) == 1);
      @(negedge clk);
      check_eq("fill_bfo", bus.buffer_full_out, i >= 2);
      check_eq("fill_ovf", bus.rx_overflow, i >= 4);
      tick();
    end
    bus.rx_ready = 1;
    @(negedge clk);
    check_eq("pop0", {bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_data}, {3'b110, HDR035});
    tick();
    @(negedge clk);
    check_eq("pop1", {bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_data}, {3'b101, 16'h0F01});
    repeat (6) tick();

    // Misaddressed packet followed by a local header-only packet
    rst = 1; tick(); rst = 0; tick();
    rdy_pct = 100;
    rx_drive(16'h0222, !ADDR_CHECK, 1, 0);
    rx_drive(16'hC001, !ADDR_CHECK, 0, 0);
    rx_drive(16'hC002, !ADDR_CHECK, 0, 1);
    rx_drive(16'h0011, 1, 1, 1);
    @(negedge clk);
    check_eq("drop_cnt", bus.rx_drop_cnt, ADDR_CHECK ? 1 : 0);
    check_eq("local_pkt", {bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_data}, {3'b111, 16'h0011});
    tick();

    // Random RX traffic with varying consumer readiness
    for (int p = 0; p < 60; p++) begin
      rdy_pct = $urandom_range(20, 100);
      rx_pkt(($urandom_range(1) != 0) ? LOCAL : 8'($urandom), 8'($urandom_range(0, 4)), 30);
    end
    bus.rx_ready = 1;
    repeat (10) tick();
    @(negedge clk); check_eq("rx_drain", bus.rx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_endpoint.md
NODE_ENDPOINT -- requirements
Module: node_endpoint

Interface
REQ-001 SHALL have parameter NODE_X, default 0, meaning the local X coordinate (4 LSBs used).
REQ-002 SHALL have parameter NODE_Y, default 0, meaning the local Y coordinate (4 LSBs used).
REQ-003 SHALL have parameter RX_DEPTH, default 4, meaning the RX buffer entry count (power of 2, >=4).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port tx_req_valid  input  1  packet request valid.
REQ-007 SHALL have port tx_req_ready  output  1  request accepted when high with valid.
REQ-008 SHALL have port tx_req_dest  input  8  destination address {x[3:0],y[3:0]}.
REQ-009 SHALL have port tx_req_len  input  8  payload flit count (0 = header only).
REQ-010 SHALL have ports tx_data_valid in 1, tx_data_ready out 1, tx_data in 16: payload stream.
REQ-011 SHALL have ports sending_data out 1, data_out out 16, buffer_full_in in 1: flits toward router local port.
REQ-012 SHALL have ports receiving_data in 1, data_in in 16, buffer_full_out out 1: flits from router local port.
REQ-013 SHALL have ports rx_valid out 1, rx_ready in 1, rx_data out 16, rx_sop out 1, rx_eop out 1: delivered stream.
REQ-014 SHALL have ports rx_overflow out 1 (sticky) and rx_drop_cnt out 8.

Function
REQ-015 Flit format SHALL be: header {len[15:8], dest[7:0]}, followed by len payload flits; local_addr = {NODE_X[3:0], NODE_Y[3:0]}.
REQ-016 A flit SHALL transfer on a cycle where sending_data=1; sending_data SHALL be 1 only when buffer_full_in=0 that cycle; data_out SHALL be 0 when sending_data=0.
REQ-017 TX FSM states SHALL be IDLE, HEAD, BODY; IDLE: tx_req_ready=1; accepted request latches dest/len -> HEAD.
REQ-018 HEAD: header sent on first cycle with buffer_full_in=0; then len==0 -> IDLE, else BODY with remaining=len.
REQ-019 BODY: tx_data_ready = !buffer_full_in; on tx_data_valid&&tx_data_ready send tx_data, decrement remaining; remaining 1 -> 0 returns to IDLE.
REQ-020 Minimum header latency SHALL be 1 cycle after request acceptance; back-to-back packets SHALL incur exactly 1 idle (IDLE) cycle.
REQ-021 RX SHALL parse headers with an RX FSM (RX_HEAD, RX_BODY, RX_DROP) tracking remaining payload flits.
REQ-022 Accepted RX flits SHALL enter the RX buffer tagged sop (header) and eop (last flit; header when len==0).
REQ-023 buffer_full_out SHALL be registered and high when RX buffer occupancy >= RX_DEPTH-1 after the current update.
REQ-024 receiving_data while RX buffer full SHALL discard the flit and set rx_overflow until reset; parse state still advances.
REQ-025 rx_valid SHALL equal buffer non-empty; pop on rx_valid&&rx_ready; simultaneous push and pop at full SHALL succeed.

Reset
REQ-026 On rst: TX->IDLE, RX->RX_HEAD, buffer empty; sending_data, data_out, rx_valid, rx_sop, rx_eop, rx_overflow, buffer_full_out, tx_data_ready =0, rx_drop_cnt=0, tx_req_ready=1 after release.
REQ-027 Reset mid-packet SHALL abandon the packet; no partial flit SHALL emit after release.

Configuration
REQ-028 With ENDPOINT_ADDR_CHECK_EN defined, headers with dest != local_addr SHALL enter RX_DROP, discard header plus len payload flits, and increment rx_drop_cnt saturating at 255.
REQ-029 Without ENDPOINT_ADDR_CHECK_EN, all packets SHALL be delivered and rx_drop_cnt SHALL be constant 0.

Structure
REQ-030 Package endpoint_pkg SHALL hold FLIT_W=16, ADDR_W=8, LEN_W=8, flit header struct, tx_state_t and rx_state_t enums.
REQ-031 The RX buffer SHALL be sub-module endpoint_rx_fifo (18-bit entries: sop, eop, flit).

Verification
REQ-032 Req dest=8'h21 len=2, data 16'hAAAA,16'hBBBB, full_in=0 -> data_out 16'h0221, AAAA, BBBB on 3 consecutive cycles, then IDLE.
REQ-033 len=0 request -> single header flit, tx_data_ready never high, next request accepted 1 cycle later.
REQ-034 buffer_full_in high 3 cycles mid-body -> sending_data=0, tx_data_ready=0 those cycles, no flit lost or duplicated.
REQ-035 RX header 16'h0100 + 1 flit, rx_ready=0 -> buffer_full_out high at occupancy 3; 5th flit sets rx_overflow; first two pop with sop then eop.
REQ-036 ENDPOINT_ADDR_CHECK_EN, NODE_X=1,NODE_Y=1, header 16'h0222 + 2 flits -> no rx_valid, rx_drop_cnt=1; following 16'h0011 delivered.
